// File: rtl/sens_power_pkg.sv
// Shared scale constants and FSM state encoding for the EMB/LCM power converters.
package sens_power_pkg;

  localparam logic [11:0] PWR_FULL_SCALE = 12'hf00;
  localparam logic [9:0]  LCM_FULL_SCALE = 10'd1023;
  localparam logic [21:0] ROUND_BIAS     = 22'd511;
  localparam int          DIV_STEPS      = 22;

  typedef enum logic {
    IDLE,
    DIV
  } state_t;

endpackage

// File: rtl/div_22b_10b_seq.sv
// 22-step restoring divider, one quotient bit per clock; startp is ignored while busy.
module div_22b_10b_seq
  import sens_power_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        startp,
  input  logic [21:0] z,
  input  logic [9:0]  d,
  output logic [21:0] q,
  output logic [9:0]  r,
  output logic        busy,
  output logic        done
);

  state_t      state;
  logic [21:0] z_sh;
  logic [20:0] q_sh;
  logic [9:0]  rem;
  logic [4:0]  cnt;

  logic [10:0] trial;
  logic        fits;
  logic [9:0]  rem_nxt;

  // The remainder is always < d, so the difference fits back into 10 bits.
  always_comb begin
    trial   = {rem, z_sh[21]};
    fits    = (trial >= {1'b0, d});
    rem_nxt = fits ? (trial[9:0] - d) : trial[9:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      z_sh  <= '0;
      q_sh  <= '0;
      rem   <= '0;
      cnt   <= '0;
      q     <= '0;
      r     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (startp) begin
            z_sh  <= z;
            q_sh  <= '0;
            rem   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= DIV;
          end
        end
        DIV: begin
          z_sh <= {z_sh[20:0], 1'b0};
          q_sh <= {q_sh[19:0], fits};
          rem  <= rem_nxt;
          cnt  <= cnt + 5'd1;
          // Final step lands its quotient bit directly in the result register.
          if (cnt == 5'(DIV_STEPS - 1)) begin
            q     <= {q_sh, fits};
            r     <= rem_nxt;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/lcm_power_convert.sv
// LCM (0..1023) to EMB sensor-scale (0..3840) power conversion via serial divide.
// Define SENS_PWR_ROUND_EN for round-to-nearest; otherwise the result is truncated.
module lcm_power_convert
  import sens_power_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  pwr_cmd,
  input  logic        cmd_startp,
  output logic [15:0] pwr_dout,
  output logic        calc_done,
  output logic        busy
);

  logic [21:0] x;
  logic [21:0] quo;
  logic [9:0]  quo_hi_unused;
  logic [9:0]  rem_unused;

  // pwr_cmd * 3840 as (pwr_cmd << 12) - (pwr_cmd << 8).
  always_comb begin
`ifdef SENS_PWR_ROUND_EN
    x = {pwr_cmd, 12'h000} - {4'h0, pwr_cmd, 8'h00} + ROUND_BIAS;
`else
    x = {pwr_cmd, 12'h000} - {4'h0, pwr_cmd, 8'h00};
`endif
  end

  div_22b_10b_seq u_div (
    .clk    (clk),
    .rst    (rst),
    .startp (cmd_startp),
    .z      (x),
    .d      (LCM_FULL_SCALE),
    .q      (quo),
    .r      (rem_unused),
    .busy   (busy),
    .done   (calc_done)
  );

  assign quo_hi_unused = quo[21:12];
  assign pwr_dout      = {4'h0, quo[11:0]};

endmodule

// File: tb/tb_lcm_power_convert.sv
// Directed checks of lcm_power_convert: scale points, timing, start-while-busy, reset, full sweep.
module tb_lcm_power_convert;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  pwr_cmd;
  logic        cmd_startp;
  logic [15:0] pwr_dout;
  logic        calc_done;
  logic        busy;

  int n_checks    = 0;
  int n_errors    = 0;
  int done_pulses = 0;

`ifdef SENS_PWR_ROUND_EN
  localparam int BIAS = 511;
  localparam int EXP_1   = 4;
  localparam int EXP_512 = 1922;
  localparam int EXP_256 = 961;
`else
  localparam int BIAS = 0;
  localparam int EXP_1   = 3;
  localparam int EXP_512 = 1921;
  localparam int EXP_256 = 960;
`endif

  lcm_power_convert dut (
    .clk        (clk),
    .rst        (rst),
    .pwr_cmd    (pwr_cmd),
    .cmd_startp (cmd_startp),
    .pwr_dout   (pwr_dout),
    .calc_done  (calc_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (calc_done) done_pulses++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ref_pwr(input int c);
    return (c * 3840 + BIAS) / 1023;
  endfunction

  // Start a conversion; returns the result and the edge count from the sampling edge (inclusive).
  task automatic run_conv(input logic [9:0] v, output logic [15:0] res, output int lat);
    @(negedge clk);
    pwr_cmd    = v;
    cmd_startp = 1'b1;
    @(posedge clk); #1;
    cmd_startp = 1'b0;
    lat = 1;
    while (!calc_done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    res = pwr_dout;
  endtask

  initial begin
    logic [15:0] res;
    int lat;
    int pulses0;
    logic early;

    rst        = 1'b0;
    cmd_startp = 1'b0;
    pwr_cmd    = '0;
    #12;
    check("reset_dout", pwr_dout, 0);
    check("reset_done", calc_done, 0);
    check("reset_busy", busy, 0);
    @(negedge clk);
    rst = 1'b1;

    // Exact scale points and latency
    run_conv(10'd0, res, lat);
    check("zero_val", res, 0);
    check("zero_lat", lat, 23);
    check("zero_busy_low", busy, 0);
    @(posedge clk); #1;
    check("zero_done_fall", calc_done, 0);

    run_conv(10'd1023, res, lat);
    check("full_val", res, 3840);
    check("full_lat", lat, 23);

    run_conv(10'd1, res, lat);
    check("one_val", res, EXP_1);
    run_conv(10'd512, res, lat);
    check("half_val", res, EXP_512);

    // Back-to-back: second start in the calc_done cycle of the first
    run_conv(10'd512, res, lat);
    check("b2b_first_val", res, EXP_512);
    check("b2b_first_lat", lat, 23);
    pwr_cmd    = 10'd1023;
    cmd_startp = 1'b1;
    @(posedge clk); #1;
    cmd_startp = 1'b0;
    lat = 1;
    check("b2b_done_fall", calc_done, 0);
    check("b2b_busy", busy, 1);
    while (!calc_done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("b2b_second_val", pwr_dout, 3840);
    check("b2b_spacing", lat, 23);

    // Start during busy is ignored
    @(negedge clk);
    pwr_cmd    = 10'd100;
    cmd_startp = 1'b1;
    @(posedge clk); #1;
    cmd_startp = 1'b0;
    lat     = 1;
    early   = 1'b0;
    pulses0 = done_pulses;
    if (!busy) early = 1'b1;
    repeat (9) begin
      @(posedge clk); #1;
      lat++;
      if (!busy) early = 1'b1;
    end
    @(negedge clk);
    pwr_cmd    = 10'd900;
    cmd_startp = 1'b1;
    @(posedge clk); #1;
    cmd_startp = 1'b0;
    lat++;
    if (!busy) early = 1'b1;
    while (!calc_done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (!busy && !calc_done) early = 1'b1;
    end
    check("busy_start_lat", lat, 23);
    check("busy_start_val", pwr_dout, 375);
    check("busy_no_early_drop", early, 0);
    repeat (30) @(posedge clk);
    #1;
    check("busy_single_done", done_pulses - pulses0, 1);
    check("busy_val_held", pwr_dout, 375);

    // Reset eight cycles into a conversion
    @(negedge clk);
    pwr_cmd    = 10'd512;
    cmd_startp = 1'b1;
    @(posedge clk); #1;
    cmd_startp = 1'b0;
    repeat (7) @(posedge clk);
    #3;
    check("pre_reset_busy", busy, 1);
    rst = 1'b0;
    #1;
    check("async_rst_dout", pwr_dout, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_done", calc_done, 0);
    pulses0 = done_pulses;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("rst_no_done", done_pulses - pulses0, 0);
    check("rst_dout_stays0", pwr_dout, 0);
    run_conv(10'd256, res, lat);
    check("post_rst_val", res, EXP_256);
    check("post_rst_lat", lat, 23);

    // Full sweep against the reference formula
    for (int c = 0; c < 1024; c++) begin
      run_conv(10'(c), res, lat);
      check($sformatf("sweep_%0d", c), res, ref_pwr(c));
      check($sformatf("sweep_hi_%0d", c), res[15:12], 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
